// File: rtl/solver_dispatch.sv
// solver_dispatch: host-side sequencer for one solver_control + datapath pair.
// It takes a job command, streams the c limbs into the solver through the
// LOAD write port, starts the solver, waits for completion and returns the
// tagged iteration count through a one-entry valid/ready result buffer.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | ready for a command; may hold a pending zero-limb error
// ST_HDR       | one cycle: write num_limbs / iter_lim into the solver
// ST_LOAD_RE   | accept real limbs re[0..n-1]
// ST_LOAD_IM   | accept imaginary limbs im[0..n-1]
// ST_START     | one-cycle start pulse to the solver
// ST_WAIT_DROP | one cycle in which out_ready may still be stale high
// ST_WAIT_DONE | wait for out_ready and a free result buffer

module solver_dispatch #(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_BITS       = 32,
    parameter int TAG_BITS        = 16
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [LIMB_INDEX_BITS-1:0] i_cmd_num_limbs,
    input  logic [15:0]                i_cmd_iter_lim,
    input  logic [TAG_BITS-1:0]        i_cmd_tag,
    input  logic                       i_limb_valid,
    output logic                       o_limb_ready,
    input  logic [LIMB_BITS-1:0]       i_limb_data,
    output logic                       o_wr_real_en,
    output logic                       o_wr_imag_en,
    output logic [LIMB_INDEX_BITS-1:0] o_wr_ind,
    output logic [LIMB_BITS-1:0]       o_c_data,
    output logic                       o_wr_num_limbs_en,
    output logic [LIMB_INDEX_BITS-1:0] o_num_limbs_data,
    output logic                       o_wr_iter_lim_en,
    output logic [15:0]                o_iter_lim_data,
    output logic                       o_start,
    input  logic                       i_solver_out_ready,
    input  logic [15:0]                i_solver_count,
    output logic                       o_res_valid,
    input  logic                       i_res_ready,
    output logic [TAG_BITS-1:0]        o_res_tag,
    output logic [15:0]                o_res_count,
    output logic                       o_res_escaped,
    output logic                       o_res_error,
    output logic                       o_busy
);

    localparam logic [LIMB_INDEX_BITS-1:0] LIMB_ONE  = LIMB_INDEX_BITS'(1);
    localparam logic [15:0]                COUNT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HDR       = 3'd1,
        ST_LOAD_RE   = 3'd2,
        ST_LOAD_IM   = 3'd3,
        ST_START     = 3'd4,
        ST_WAIT_DROP = 3'd5,
        ST_WAIT_DONE = 3'd6
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;

    logic [LIMB_INDEX_BITS-1:0]   r_num_limbs;
    logic [15:0]                  r_iter_lim;
    logic [TAG_BITS-1:0]          r_tag;
    logic [LIMB_INDEX_BITS-1:0]   r_idx;
    logic [LIMB_INDEX_BITS-1:0]   w_idx_next;
    logic                         r_err_pend;

    logic                         r_buf_full;
    logic [TAG_BITS-1:0]          r_buf_tag;
    logic [15:0]                  r_buf_count;
    logic                         r_buf_escaped;
    logic                         r_buf_error;

    logic                         w_cmd_ready;
    logic                         w_cmd_fire;
    logic                         w_cmd_zero;
    logic                         w_limb_ready;
    logic                         w_limb_fire;
    logic                         w_last_limb;
    logic                         w_buf_free;
    logic                         w_cap_job;
    logic                         w_cap_err;

    // Handshake qualifiers; cmd_ready depends only on registered state (and
    // reset), never on res_ready.
    always_comb begin
        w_cmd_ready  = (r_state == ST_IDLE) && !r_err_pend && !i_reset;
        w_cmd_fire   = i_cmd_valid && w_cmd_ready;
        w_cmd_zero   = (i_cmd_num_limbs == '0);
        w_limb_ready = (r_state == ST_LOAD_RE) || (r_state == ST_LOAD_IM);
        w_limb_fire  = i_limb_valid && w_limb_ready;
        w_last_limb  = (r_idx == (r_num_limbs - LIMB_ONE));
        // A slot is free when empty or being drained this cycle; the new
        // entry overwrites the drained one.
        w_buf_free   = !r_buf_full || i_res_ready;
        w_cap_err    = r_err_pend && w_buf_free;
    end

    // Next-state, index counter and solver-side strobes.
    always_comb begin
        w_state_next      = r_state;
        w_idx_next        = r_idx;
        o_wr_real_en      = 1'b0;
        o_wr_imag_en      = 1'b0;
        o_wr_num_limbs_en = 1'b0;
        o_wr_iter_lim_en  = 1'b0;
        o_start           = 1'b0;
        w_cap_job         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire && !w_cmd_zero) begin
                    w_state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                o_wr_num_limbs_en = 1'b1;
                o_wr_iter_lim_en  = 1'b1;
                w_idx_next        = '0;
                w_state_next      = ST_LOAD_RE;
            end
            ST_LOAD_RE: begin
                if (w_limb_fire) begin
                    o_wr_real_en = 1'b1;
                    if (w_last_limb) begin
                        w_idx_next   = '0;
                        w_state_next = ST_LOAD_IM;
                    end else begin
                        w_idx_next = r_idx + LIMB_ONE;
                    end
                end
            end
            ST_LOAD_IM: begin
                if (w_limb_fire) begin
                    o_wr_imag_en = 1'b1;
                    if (w_last_limb) begin
                        w_idx_next   = '0;
                        w_state_next = ST_START;
                    end else begin
                        w_idx_next = r_idx + LIMB_ONE;
                    end
                end
            end
            ST_START: begin
                o_start      = 1'b1;
                w_state_next = ST_WAIT_DROP;
            end
            ST_WAIT_DROP: begin
                w_state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_solver_out_ready && w_buf_free) begin
                    w_cap_job    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register and limb index counter.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Command capture; also remembers a zero-limb job until its error result
    // can be placed in the buffer.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_num_limbs <= '0;
            r_iter_lim  <= '0;
            r_tag       <= '0;
            r_err_pend  <= 1'b0;
        end else begin
            if (w_cmd_fire) begin
                r_num_limbs <= i_cmd_num_limbs;
                r_iter_lim  <= i_cmd_iter_lim;
                r_tag       <= i_cmd_tag;
            end
            if (w_cmd_fire && w_cmd_zero) begin
                r_err_pend <= 1'b1;
            end else if (w_cap_err) begin
                r_err_pend <= 1'b0;
            end
        end
    end

    // One-entry result buffer; a capture takes priority over a drain.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_buf_full    <= 1'b0;
            r_buf_tag     <= '0;
            r_buf_count   <= '0;
            r_buf_escaped <= 1'b0;
            r_buf_error   <= 1'b0;
        end else if (w_cap_job) begin
            r_buf_full    <= 1'b1;
            r_buf_tag     <= r_tag;
            r_buf_count   <= i_solver_count;
            r_buf_escaped <= (i_solver_count != COUNT_MAX);
            r_buf_error   <= 1'b0;
        end else if (w_cap_err) begin
            r_buf_full    <= 1'b1;
            r_buf_tag     <= r_tag;
            r_buf_count   <= '0;
            r_buf_escaped <= 1'b0;
            r_buf_error   <= 1'b1;
        end else if (r_buf_full && i_res_ready) begin
            r_buf_full <= 1'b0;
        end
    end

    assign o_cmd_ready      = w_cmd_ready;
    assign o_limb_ready     = w_limb_ready;
    assign o_wr_ind         = r_idx;
    assign o_c_data         = i_limb_data;
    assign o_num_limbs_data = r_num_limbs;
    assign o_iter_lim_data  = r_iter_lim;
    assign o_res_valid      = r_buf_full;
    assign o_res_tag        = r_buf_tag;
    assign o_res_count      = r_buf_count;
    assign o_res_escaped    = r_buf_escaped;
    assign o_res_error      = r_buf_error;
    assign o_busy           = (r_state != ST_IDLE);

endmodule
